// File: rtl/systolic_result_drain_if.sv
// Row-major result element stream produced by systolic_result_drain.
// master = element source (drain), slave = downstream consumer.
interface systolic_result_drain_if #(
   parameter int unsigned SYS_ARRAY_SIZE = 4,
   parameter int unsigned DATA_W         = 16
);
   localparam int unsigned IDX_W = (SYS_ARRAY_SIZE > 1) ? $clog2(SYS_ARRAY_SIZE) : 1;

   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic [IDX_W-1:0]  out_row_o;
   logic [IDX_W-1:0]  out_col_o;
   logic              out_last_o;

   modport master (
      output out_valid_o,
      output out_data_o,
      output out_row_o,
      output out_col_o,
      output out_last_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_data_o,
      input  out_row_o,
      input  out_col_o,
      input  out_last_o,
      output out_ready_i
   );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures the NxN result matrix from the systolic array a fixed delay after
// the operand 'last' beat, then streams it out row-major over valid/ready.
module systolic_result_drain #(
   parameter int unsigned SYS_ARRAY_SIZE = 4,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned DRAIN_DELAY    = 2*SYS_ARRAY_SIZE+2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 last_i,
   input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0] c_i,
   systolic_result_drain_if.master              out_if,
   output logic                                 busy_o,
   output logic                                 overflow_o
);
   localparam int unsigned N     = SYS_ARRAY_SIZE;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W = $clog2(DRAIN_DELAY + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_DELAY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPTURE, ST_EMIT} state_t;

   state_t                     r_state, w_state_nx;
   logic [CNT_W-1:0]           r_cnt, w_cnt_nx;
   logic [IDX_W-1:0]           r_cap_row, w_cap_row_nx;
   logic [IDX_W-1:0]           r_row, w_row_nx;
   logic [IDX_W-1:0]           r_col, w_col_nx;
   logic                       r_valid, w_valid_nx;
   logic [DATA_W-1:0]          r_data, w_data_nx;
   logic                       r_last, w_last_nx;
   logic                       r_busy;
   logic                       r_ovf, w_ovf_nx;
   logic                       w_wr_en;
   logic                       w_xfer;
   logic                       w_accept;
   logic [N-1:0][DATA_W-1:0]   r_buf [N];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_cap_row <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_last    <= 1'b0;
         r_busy    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_cap_row <= w_cap_row_nx;
         r_row     <= w_row_nx;
         r_col     <= w_col_nx;
         r_valid   <= w_valid_nx;
         r_data    <= w_data_nx;
         r_last    <= w_last_nx;
         r_busy    <= (w_state_nx != ST_IDLE);
         r_ovf     <= w_ovf_nx;
      end
   end

   // Buffer holds don't-care data after reset, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_buf[r_cap_row] <= c_i;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_cap_row_nx = r_cap_row;
      w_row_nx     = r_row;
      w_col_nx     = r_col;
      w_valid_nx   = r_valid;
      w_data_nx    = r_data;
      w_last_nx    = r_last;
      w_ovf_nx     = r_ovf;
      w_wr_en      = 1'b0;
      w_accept     = 1'b0;
      w_xfer       = r_valid & out_if.out_ready_i;

      unique case (r_state)
         ST_IDLE: begin
            w_accept = last_i;
         end
         // Leave WAIT one edge early so the first CAPTURE edge lands at t0+DRAIN_DELAY.
         ST_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nx = ST_CAPTURE;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            w_wr_en = 1'b1;
            if (r_cap_row == IDX_LAST) begin
               w_state_nx = ST_EMIT;
               w_row_nx   = '0;
               w_col_nx   = '0;
               w_valid_nx = 1'b1;
               w_data_nx  = (r_cap_row == '0) ? c_i[0] : r_buf[0][0];
               w_last_nx  = (N == 1);
            end else begin
               w_cap_row_nx = r_cap_row + IDX_W'(1);
            end
         end
         ST_EMIT: begin
            if (w_xfer) begin
               if (r_col == IDX_LAST) begin
                  w_col_nx = '0;
                  w_row_nx = (r_row == IDX_LAST) ? '0 : r_row + IDX_W'(1);
               end else begin
                  w_col_nx = r_col + IDX_W'(1);
               end
               w_data_nx = r_buf[w_row_nx][w_col_nx];
               w_last_nx = (w_row_nx == IDX_LAST) && (w_col_nx == IDX_LAST);
               if (r_last) begin
                  w_state_nx = ST_IDLE;
                  w_valid_nx = 1'b0;
                  w_last_nx  = 1'b0;
                  w_accept   = last_i;
               end
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase

      if (w_accept) begin
         w_state_nx   = (DRAIN_DELAY == 1) ? ST_CAPTURE : ST_WAIT;
         w_cnt_nx     = CNT_LOAD;
         w_cap_row_nx = '0;
      end else if (last_i) begin
         w_ovf_nx = 1'b1;
      end
   end

   assign out_if.out_valid_o = r_valid;
   assign out_if.out_data_o  = r_data;
   assign out_if.out_row_o   = r_row;
   assign out_if.out_col_o   = r_col;
   assign out_if.out_last_o  = r_last;
   assign busy_o             = r_busy;
   assign overflow_o         = r_ovf;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Two drains (DRAIN_DELAY 10 and 1) fed identical random stimulus and compared
// against a cycle-count model of capture windows and row-major emission.
module tb_systolic_result_drain;
   localparam int N  = 4;
   localparam int NN = N * N;
   localparam int DW = 16;

   logic                   clk;
   logic                   rst_n;
   logic                   last;
   logic                   ready;
   logic [N-1:0][DW-1:0]   c;
   logic                   busy0, busy1, ovf0, ovf1;

   systolic_result_drain_if #(.SYS_ARRAY_SIZE(N), .DATA_W(DW)) if0 ();
   systolic_result_drain_if #(.SYS_ARRAY_SIZE(N), .DATA_W(DW)) if1 ();

   assign if0.out_ready_i = ready;
   assign if1.out_ready_i = ready;

   systolic_result_drain #(.SYS_ARRAY_SIZE(N), .DATA_W(DW), .DRAIN_DELAY(10)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .last_i(last), .c_i(c),
      .out_if(if0.master), .busy_o(busy0), .overflow_o(ovf0)
   );

   systolic_result_drain #(.SYS_ARRAY_SIZE(N), .DATA_W(DW), .DRAIN_DELAY(1)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .last_i(last), .c_i(c),
      .out_if(if1.master), .busy_o(busy1), .overflow_o(ovf1)
   );

   logic          g_valid [2];
   logic [DW-1:0] g_data  [2];
   logic [1:0]    g_row   [2];
   logic [1:0]    g_col   [2];
   logic          g_last  [2];
   logic          g_busy  [2];
   logic          g_ovf   [2];

   assign g_valid[0] = if0.out_valid_o;  assign g_valid[1] = if1.out_valid_o;
   assign g_data[0]  = if0.out_data_o;   assign g_data[1]  = if1.out_data_o;
   assign g_row[0]   = if0.out_row_o;    assign g_row[1]   = if1.out_row_o;
   assign g_col[0]   = if0.out_col_o;    assign g_col[1]   = if1.out_col_o;
   assign g_last[0]  = if0.out_last_o;   assign g_last[1]  = if1.out_last_o;
   assign g_busy[0]  = busy0;            assign g_busy[1]  = busy1;
   assign g_ovf[0]   = ovf0;             assign g_ovf[1]   = ovf1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int edge_n = 0;

   // Model: accepted matrix start edge, elements sent, captured values.
   bit            m_busy  [2];
   bit            m_ovf   [2];
   int            m_start [2];
   int            m_sent  [2];
   logic [DW-1:0] m_mat   [2][NN];

   function automatic int dly(input int k);
      return (k == 0) ? 10 : 1;
   endfunction

   // Valid in the cycle after edge e.
   function automatic bit exp_valid(input int k, input int e);
      return m_busy[k] && (e >= m_start[k] + dly(k) + N - 1) && (m_sent[k] < NN);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         m_ovf[k]  = 1'b0;
         m_sent[k] = 0;
         m_start[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input bit l, input bit rdy,
                             input logic [N-1:0][DW-1:0] cv);
      bit vld;
      int r;
      vld = exp_valid(k, edge_n - 1);
      r = edge_n - m_start[k] - dly(k);
      if (m_busy[k] && r >= 0 && r < N)
         for (int j = 0; j < N; j++) m_mat[k][r*N + j] = cv[j];
      if (vld && rdy) begin
         m_sent[k]++;
         if (m_sent[k] == NN) m_busy[k] = 1'b0;
      end
      if (l) begin
         if (!m_busy[k]) begin
            m_busy[k]  = 1'b1;
            m_start[k] = edge_n;
            m_sent[k]  = 0;
         end else begin
            m_ovf[k] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      bit v;
      for (int k = 0; k < 2; k++) begin
         v = exp_valid(k, edge_n);
         chk($sformatf("d%0d.valid@%0d", k, edge_n), 32'(g_valid[k]), 32'(v));
         chk($sformatf("d%0d.busy@%0d", k, edge_n), 32'(g_busy[k]), 32'(m_busy[k]));
         chk($sformatf("d%0d.ovf@%0d", k, edge_n), 32'(g_ovf[k]), 32'(m_ovf[k]));
         if (v) begin
            chk($sformatf("d%0d.data@%0d", k, edge_n), 32'(g_data[k]), 32'(m_mat[k][m_sent[k]]));
            chk($sformatf("d%0d.row@%0d", k, edge_n), 32'(g_row[k]), 32'(m_sent[k] / N));
            chk($sformatf("d%0d.col@%0d", k, edge_n), 32'(g_col[k]), 32'(m_sent[k] % N));
            chk($sformatf("d%0d.last@%0d", k, edge_n), 32'(g_last[k]), 32'(m_sent[k] == NN - 1));
         end
         if (!rst_n) begin
            chk($sformatf("d%0d.rst_data@%0d", k, edge_n), 32'(g_data[k]), 32'd0);
            chk($sformatf("d%0d.rst_row@%0d", k, edge_n), 32'(g_row[k]), 32'd0);
            chk($sformatf("d%0d.rst_col@%0d", k, edge_n), 32'(g_col[k]), 32'd0);
            chk($sformatf("d%0d.rst_last@%0d", k, edge_n), 32'(g_last[k]), 32'd0);
         end
      end
   endtask

   task automatic tick(input bit l, input bit rdy);
      logic [N-1:0][DW-1:0] cv;
      for (int j = 0; j < N; j++) cv[j] = DW'($urandom);
      last  = l;
      ready = rdy;
      c     = cv;
      @(posedge clk);
      edge_n++;
      if (rst_n)
         for (int k = 0; k < 2; k++) model_edge(k, l, rdy, cv);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      last = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         edge_n++;
         #1;
         check_all();
      end
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      bit hit;
      rst_n = 1'b0;
      last  = 1'b0;
      ready = 1'b0;
      c     = '0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b1);

      // Basic, ready held high
      tick(1'b1, 1'b1);
      repeat (32) tick(1'b0, 1'b1);

      // Backpressure, ready pattern 1,0,0,1,0,0,...
      tick(1'b1, 1'b1);
      for (int i = 0; i < 65; i++) tick(1'b0, (i % 3) == 2);

      // Back-to-back: last lands on the edge of dut0's final transfer
      tick(1'b1, 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (exp_valid(0, edge_n) && m_sent[0] == NN - 1) begin
            tick(1'b1, 1'b1);
            hit = 1'b1;
         end else begin
            tick(1'b0, 1'b1);
         end
      end
      chk("b2b.reached_final_edge", 32'(hit), 32'd1);
      repeat (34) tick(1'b0, 1'b1);

      // Reset after dut0 has captured rows 0 and 1
      tick(1'b1, 1'b1);
      repeat (11) tick(1'b0, 1'b1);
      do_reset();
      tick(1'b1, 1'b1);
      repeat (34) tick(1'b0, 1'b1);

      // Overflow: extra last during WAIT and during EMIT
      tick(1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      repeat (10) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      repeat (30) tick(1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);

      do_reset();
      repeat (2) tick(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result-side companion of `systolic_array_wrap`. It captures the N×N result matrix that the array presents on its `c` bus row by row after a `last` beat. It then streams the elements out one per transfer, row-major, over a valid/ready interface. It sits between the array's `c` output and the result write-back/checker path. It mirrors the operand-side producer that drives `a`/`b`/`last`.

## Interface
Parameters:
- `SYS_ARRAY_SIZE`, default common_pkg value (4): N, array dimension; rows and columns of the result.
- `DATA_W`, default `$bits(data_t)`: element width.
- `DRAIN_DELAY`, default `2*SYS_ARRAY_SIZE+2`: cycles from the `last_i` sample edge to the first result-row capture edge; legal range ≥1.

Ports:
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `last_i`  in  1  one-cycle pulse, same signal driven to the array: final operand beat of a matrix.
- `c_i`  in  N×DATA_W  result row from the array; column j in element j.
- `out_valid_o`  out  1  element available.
- `out_ready_i`  in  1  downstream accepts element.
- `out_data_o`  out  DATA_W  element value.
- `out_row_o`  out  $clog2(N)  row index of element.
- `out_col_o`  out  $clog2(N)  column index of element.
- `out_last_o`  out  1  element is (N-1, N-1).
- `busy_o`  out  1  state ≠ IDLE.
- `overflow_o`  out  1  sticky: `last_i` was rejected.

## Operation
- Internal N×N buffer; single matrix in flight.
- States:
  - IDLE: on `last_i`=1, load delay counter with DRAIN_DELAY-1 and go to WAIT. If DRAIN_DELAY=1, go directly to CAPTURE.
  - WAIT: decrement the counter each cycle; at 0, go to CAPTURE.
  - CAPTURE: on each of N consecutive edges, write `c_i` into buffer row r (r=0..N-1). After row N-1, go to EMIT with r=c=0.
  - EMIT: present buffer[row][col].
    - On each transfer (`out_valid_o` & `out_ready_i` at an edge), advance col; wrap col to 0 and increment row.
    - The transfer with `out_last_o`=1 returns to IDLE.
- Capture cannot stall; the array has no backpressure. `out_ready_i` is ignored outside EMIT.
- `last_i`=1 while in WAIT, CAPTURE or EMIT:
  - The pulse is ignored and `overflow_o` sets to 1 at that edge.
  - The ongoing matrix is unaffected.
  - Exception: `last_i`=1 on the same edge as the final transfer (`out_last_o` accepted) is accepted. The block goes straight to WAIT with the counter loaded.
- `overflow_o` clears only on reset.
- Values pass through unmodified; no arithmetic on data. Row/col counters are modulo N.

## Timing
- Reset values:
  - `out_valid_o`=0, `out_data_o`=0, `out_row_o`=0, `out_col_o`=0, `out_last_o`=0, `busy_o`=0, `overflow_o`=0.
  - State is IDLE.
  - Buffer contents are don't-care and not observable.
- Reset asserted mid-operation aborts immediately, asynchronously. Outputs return to reset values while `rst_i`=0. The partial matrix is discarded.
- Capture timing, with `last_i` sampled at edge t0:
  - Row r is captured at edge t0+DRAIN_DELAY+r.
  - `busy_o`=1 from after t0.
- EMIT timing:
  - `out_valid_o`=1 starting the cycle after the row N-1 capture edge, i.e. after edge t0+DRAIN_DELAY+N-1.
  - Element (0,0) is first visible then.
- With `out_ready_i` held 1, one element transfers per cycle; N² cycles in EMIT.
- All outputs are registered.
- Handshake:
  - While valid and not ready, `out_data_o`, `out_row_o`, `out_col_o` and `out_last_o` hold stable.
  - Valid is never withdrawn before transfer.
- After the final transfer, `out_valid_o`=0 and `busy_o`=0 in the next cycle, unless a new `last_i` was accepted on that edge, in which case `busy_o` stays 1.

## Test plan
Setup: N=4, DRAIN_DELAY=10. Drive `c_i`[j] = 16·r+j on capture cycle r; drive `c_i` = 0xFF in all other cycles.

- Basic: `last_i` pulse at t0, `out_ready_i`=1 -> 16 transfers on consecutive cycles.
  - The first transfer is visible after edge t0+13.
  - Data is 0,1,2,3,16,…,51; row/col match.
  - `out_last_o` only on 51.
  - `busy_o` falls after the last transfer.
- Backpressure: `out_ready_i` toggles 1,0,0,1,… -> same 16 values in order; outputs stable during stalls; no duplicates or drops.
- Overflow: second `last_i` during WAIT and another during EMIT -> `overflow_o`=1 and stays 1; the output sequence is unchanged; no second matrix.
- Back-to-back: `last_i` on the same edge as the final transfer -> accepted; second matrix capture at that edge +10..+13; `overflow_o`=0.
- Reset mid-CAPTURE: `rst_i`=0 after row 1 -> all outputs 0 immediately. After release, a fresh `last_i` yields a correct full matrix.
- DRAIN_DELAY=1 variant: capture row 0 at edge t0+1 -> `out_valid_o` after edge t0+4.
